// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
// Optional same-cycle writeback bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 3;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps one register index per cycle after reset or clear_req,
// then holds RUN until the next clear request.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear_req,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx,
    output state_t        state
);

    localparam logic [AW-1:0] LAST_IDX = '1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    // A repeated request restarts the sweep so every index is zeroed again.
                    if (clear_req) begin
                        clr_idx <= '0;
                    end else if (clr_idx == LAST_IDX) begin
                        state   <= RUN;
                        ready   <= 1'b1;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                RUN: begin
                    if (clear_req) begin
                        state   <= CLEAR;
                        ready   <= 1'b0;
                        clr_idx <= '0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    ready   <= 1'b0;
                    clr_idx <= '0;
                end
            endcase
        end
    end

    assign clr_we = (state == CLEAR);

endmodule

// File: rtl/reg_file_sb.sv
// Two-read register file with a per-register busy scoreboard and a clearing sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear_req,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    input  logic          imm_sel,
    input  logic [DW-1:0] imm_value,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_addr,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          busy_a,
    output logic          busy_b,
    output logic          stall,
    output logic          ready,
    output state_t        fsm_state
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             clr_we;
    logic [AW-1:0]    clr_idx;
    logic             wb_ok;
    logic             issue_ok;
    logic [DW-1:0]    stored_a, stored_b, data_a, data_b;
    logic             bsy_a, bsy_b;

    regfile_clear_seq #(.AW(AW)) u_clear_seq (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear_req(clear_req),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx),
        .state    (fsm_state)
    );

    // issue_valid and wb_valid are single-cycle strobes taken at the edge only while
    // ready=1; there is no backpressure, stall only tells the consumer read data is unusable.
    assign wb_ok    = ready && wb_valid && !(R0_ZERO && (wb_addr == '0));
    assign issue_ok = ready && issue_valid && !(R0_ZERO && (issue_addr == '0));

    always_ff @(posedge clock) begin
        if (clr_we) begin
            regs[clr_idx] <= '0;
        end else if (wb_ok) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else if (!ready || clear_req) begin
            busy <= '0;
        end else begin
            if (wb_ok) begin
                busy[wb_addr] <= 1'b0;
            end
            // Issue after writeback so a same-address pair leaves the register busy.
            if (issue_ok) begin
                busy[issue_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        stored_a = (R0_ZERO && (rd_addr_a == '0)) ? '0 : regs[rd_addr_a];
        stored_b = (R0_ZERO && (rd_addr_b == '0)) ? '0 : regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        data_a = stored_a;
        bsy_a  = busy[rd_addr_a];
        if (wb_ok && (wb_addr == rd_addr_a)) begin
            data_a = wb_data;
            bsy_a  = issue_ok && (issue_addr == rd_addr_a);
        end
        data_b = stored_b;
        bsy_b  = busy[rd_addr_b];
        if (wb_ok && (wb_addr == rd_addr_b)) begin
            data_b = wb_data;
            bsy_b  = issue_ok && (issue_addr == rd_addr_b);
        end
`else
        data_a = stored_a;
        bsy_a  = busy[rd_addr_a];
        data_b = stored_b;
        bsy_b  = busy[rd_addr_b];
`endif
    end

    assign rd_data_a = data_a;
    assign rd_data_b = imm_sel ? imm_value : data_b;
    assign busy_a    = bsy_a;
    assign busy_b    = bsy_b & ~imm_sel;
    assign stall     = ~ready | busy_a | busy_b;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (R0_ZERO=0 and 1) against a behavioural model,
// directed scenarios with literal expectations, then randomized traffic with clears and resets.
module tb_reg_file_sb;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       clear_req;
    logic [2:0] rd_addr_a, rd_addr_b, issue_addr, wb_addr;
    logic       imm_sel, issue_valid, wb_valid;
    logic [7:0] imm_value, wb_data;

    logic [7:0] rd_a [2];
    logic [7:0] rd_b [2];
    logic       bz_a [2];
    logic       bz_b [2];
    logic       stl  [2];
    logic       rdy  [2];
    state_t     fsm_st [2];

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    // Behavioural model: index 0 is the plain instance, index 1 the R0_ZERO instance.
    logic [7:0] m_mem  [2][8];
    bit         m_busy [2][8];
    int         m_left = 8;

    always #5 clock = ~clock;

    reg_file_sb #(.DW(8), .AW(3), .R0_ZERO(1'b0)) dut (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .imm_sel(imm_sel), .imm_value(imm_value),
        .rd_data_a(rd_a[0]), .rd_data_b(rd_b[0]),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy_a(bz_a[0]), .busy_b(bz_b[0]), .stall(stl[0]), .ready(rdy[0]), .fsm_state(fsm_st[0])
    );

    reg_file_sb #(.DW(8), .AW(3), .R0_ZERO(1'b1)) dut_z (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .imm_sel(imm_sel), .imm_value(imm_value),
        .rd_data_a(rd_a[1]), .rd_data_b(rd_b[1]),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy_a(bz_a[1]), .busy_b(bz_b[1]), .stall(stl[1]), .ready(rdy[1]), .fsm_state(fsm_st[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_ready();
        return reset_n && (m_left == 0);
    endfunction

    function automatic bit m_hit(int k, logic [2:0] a);
        return BYP && m_ready() && wb_valid && (wb_addr == a) && !(k == 1 && a == 3'd0);
    endfunction

    function automatic logic [7:0] m_rd(int k, logic [2:0] a);
        if (k == 1 && a == 3'd0) return 8'h00;
        if (m_hit(k, a)) return wb_data;
        return m_mem[k][a];
    endfunction

    function automatic bit m_bsy(int k, logic [2:0] a);
        if (!m_ready()) return 1'b0;
        if (m_hit(k, a)) return issue_valid && (issue_addr == a);
        return m_busy[k][a];
    endfunction

    // Model update at each rising edge from the inputs held during the cycle.
    always @(posedge clock) begin
        if (!reset_n) begin
            m_left = 8;
            for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) m_busy[k][i] = 1'b0;
        end else if (m_left > 0) begin
            if (clear_req) m_left = 8;
            else begin
                m_left = m_left - 1;
                if (m_left == 0)
                    for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) m_mem[k][i] = 8'h00;
            end
        end else if (clear_req) begin
            m_left = 8;
            for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) m_busy[k][i] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wb_valid && !(k == 1 && wb_addr == 3'd0)) begin
                    m_mem[k][wb_addr]  = wb_data;
                    m_busy[k][wb_addr] = 1'b0;
                end
                if (issue_valid && !(k == 1 && issue_addr == 3'd0)) m_busy[k][issue_addr] = 1'b1;
            end
        end
    end

    // Compare process: every cycle, 2 time units after the input change at the falling edge.
    always @(negedge clock) begin
        #2;
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                logic eb_a, eb_b;
                eb_a = m_bsy(k, rd_addr_a);
                eb_b = imm_sel ? 1'b0 : m_bsy(k, rd_addr_b);
                chk("ready", rdy[k], m_ready());
                chk("state", fsm_st[k], m_ready() ? 1 : 0);
                chk("busy_a", bz_a[k], eb_a);
                chk("busy_b", bz_b[k], eb_b);
                chk("stall", stl[k], !m_ready() || eb_a || eb_b);
                if (m_ready()) begin
                    chk("rd_data_a", rd_a[k], m_rd(k, rd_addr_a));
                    chk("rd_data_b", rd_b[k], imm_sel ? imm_value : m_rd(k, rd_addr_b));
                end
            end
        end
    end

    task automatic idle();
        clear_req = 1'b0; rd_addr_a = 3'd0; rd_addr_b = 3'd0; imm_sel = 1'b0; imm_value = 8'h00;
        issue_valid = 1'b0; issue_addr = 3'd0; wb_valid = 1'b0; wb_addr = 3'd0; wb_data = 8'h00;
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        #3;
        chk("reset_ready", rdy[0], 1'b0);
        chk("reset_stall", stl[0], 1'b1);
        tick(); tick();
        cmp_en  = 1'b1;
        reset_n = 1'b1;

        // Sweep after reset: 8 cycles not ready, then every register reads 0.
        for (int i = 0; i < 8; i++) begin
            #3 chk("sweep_ready_lo", rdy[0], 1'b0);
            tick();
        end
        #3 chk("sweep_ready_hi", rdy[0], 1'b1);
        for (int i = 0; i < 8; i++) begin
            idle(); rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
            #3 chk("init_zero_a", rd_a[0], 8'h00);
            chk("init_zero_b", rd_b[0], 8'h00);
            tick();
        end

        // Issue r5, see it busy, write it back, see data and busy released.
        idle(); issue_valid = 1'b1; issue_addr = 3'd5; tick();
        idle(); rd_addr_a = 3'd5;
        #3 chk("r5_busy", bz_a[0], 1'b1);
        chk("r5_stall", stl[0], 1'b1);
        tick();
        idle(); wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 8'h3C; tick();
        idle(); rd_addr_a = 3'd5;
        #3 chk("r5_free", bz_a[0], 1'b0);
        chk("r5_data", rd_a[0], 8'h3C);
        tick();

        // Same-cycle issue and writeback of r2: data lands, register stays busy.
        idle(); issue_valid = 1'b1; issue_addr = 3'd2; wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 8'h11;
        tick();
        idle(); rd_addr_a = 3'd2;
        #3 chk("r2_data", rd_a[0], 8'h11);
        chk("r2_busy", bz_a[0], 1'b1);
        tick();

        // Immediate on port B hides a busy r3.
        idle(); issue_valid = 1'b1; issue_addr = 3'd3; tick();
        idle(); imm_sel = 1'b1; imm_value = 8'h7F; rd_addr_b = 3'd3; rd_addr_a = 3'd0;
        #3 chk("imm_data", rd_b[0], 8'h7F);
        chk("imm_busy_b", bz_b[0], 1'b0);
        chk("imm_stall", stl[0], 1'b0);
        tick();

        // Writeback to r4 while reading it.
        idle(); wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 8'h22; tick();
        idle(); wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 8'hA5; rd_addr_a = 3'd4;
        #3 chk("r4_same_cycle", rd_a[0], BYP ? 8'hA5 : 8'h22);
        chk("r4_same_busy", bz_a[0], 1'b0);
        tick();
        idle(); rd_addr_a = 3'd4;
        #3 chk("r4_next_cycle", rd_a[0], 8'hA5);
        tick();

        // Register 0 on the R0_ZERO instance ignores writes and issues.
        idle(); wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 8'hFF; tick();
        idle(); issue_valid = 1'b1; issue_addr = 3'd0; tick();
        idle(); rd_addr_a = 3'd0;
        #3 chk("r0z_data", rd_a[1], 8'h00);
        chk("r0z_busy", bz_a[1], 1'b0);
        chk("r0_plain_data", rd_a[0], 8'hFF);
        chk("r0_plain_busy", bz_a[0], 1'b1);
        tick();

        // Clear in RUN with r1 written and busy.
        idle(); wb_valid = 1'b1; wb_addr = 3'd1; wb_data = 8'h55; issue_valid = 1'b1; issue_addr = 3'd1;
        tick();
        idle(); rd_addr_a = 3'd1;
        #3 chk("r1_data", rd_a[0], 8'h55);
        chk("r1_busy", bz_a[0], 1'b1);
        tick();
        idle(); clear_req = 1'b1; tick();
        idle(); rd_addr_a = 3'd1;
        for (int i = 0; i < 8; i++) begin
            #3 chk("clr_ready_lo", rdy[0], 1'b0);
            chk("clr_busy", bz_a[0], 1'b0);
            tick();
        end
        #3 chk("clr_ready_hi", rdy[0], 1'b1);
        chk("clr_r1_zero", rd_a[0], 8'h00);
        chk("clr_r1_free", bz_a[0], 1'b0);
        tick();

        // Randomized traffic with occasional clears and reset pulses.
        for (int c = 0; c < 3000; c++) begin
            reset_n     = ($urandom_range(0, 399) != 0);
            clear_req   = ($urandom_range(0, 79) == 0);
            rd_addr_a   = 3'($urandom_range(0, 7));
            rd_addr_b   = 3'($urandom_range(0, 7));
            imm_sel     = ($urandom_range(0, 3) == 0);
            imm_value   = 8'($urandom_range(0, 255));
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_addr  = 3'($urandom_range(0, 7));
            wb_valid    = ($urandom_range(0, 1) == 0);
            wb_addr     = ($urandom_range(0, 2) == 0) ? rd_addr_a : 3'($urandom_range(0, 7));
            wb_data     = 8'($urandom_range(0, 255));
            tick();
        end
        reset_n = 1'b1;
        idle();
        tick();
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DW, default 8, data width in bits.
REQ-002 Parameter AW, default 3, address width; depth is 2**AW registers.
REQ-003 Parameter R0_ZERO, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-004 Port clock  input  1  single clock; all state changes on the rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port clear_req  input  1  request a full register-array clear.
REQ-007 Port rd_addr_a  input  AW  read port A address.
REQ-008 Port rd_addr_b  input  AW  read port B address.
REQ-009 Port imm_sel  input  1  port B returns imm_value instead of a register.
REQ-010 Port imm_value  input  DW  immediate operand.
REQ-011 Port rd_data_a  output  DW  port A data.
REQ-012 Port rd_data_b  output  DW  port B data.
REQ-013 Port issue_valid  input  1  mark issue_addr busy (pending writeback).
REQ-014 Port issue_addr  input  AW  destination being issued.
REQ-015 Port wb_valid  input  1  writeback strobe.
REQ-016 Port wb_addr  input  AW  writeback address.
REQ-017 Port wb_data  input  DW  writeback data.
REQ-018 Port busy_a / busy_b  output  1 each  addressed register has a pending write.
REQ-019 Port stall  output  1  consumer must not use read data this cycle.
REQ-020 Port ready  output  1  array initialised and accepting traffic.

Function
REQ-021 The FSM SHALL have two states: CLEAR (ready=0) and RUN (ready=1).
REQ-022 In CLEAR, one register per cycle SHALL be zeroed at an index counter 0..2**AW-1; after the last index the FSM SHALL enter RUN on the next edge, so CLEAR lasts exactly 2**AW cycles.
REQ-023 In RUN, clear_req=1 SHALL move the FSM to CLEAR with the counter at 0 and all busy bits cleared; clear_req in CLEAR SHALL restart the counter at 0.
REQ-024 Reads SHALL be combinational: rd_data_a = reg[rd_addr_a]; rd_data_b = imm_sel ? imm_value : reg[rd_addr_b].
REQ-025 In RUN, wb_valid SHALL write wb_data to reg[wb_addr] at the edge and clear busy[wb_addr].
REQ-026 In RUN, issue_valid SHALL set busy[issue_addr] at the edge; if issue and writeback target the same address in one cycle, set SHALL win (busy stays 1, data written).
REQ-027 wb_valid and issue_valid SHALL be ignored in CLEAR.
REQ-028 busy_a = busy[rd_addr_a]; busy_b = busy[rd_addr_b] & ~imm_sel.
REQ-029 stall = ~ready | busy_a | busy_b.
REQ-030 With R0_ZERO=1, reads of address 0 SHALL return 0, writes to 0 SHALL be dropped, and busy[0] SHALL never set.

Reset
REQ-031 reset_n low SHALL immediately force CLEAR, counter 0, all busy bits 0, ready 0; register contents are undefined until the CLEAR sweep completes.
REQ-032 Reset SHALL be honoured mid-sweep and mid-traffic with the same result; rd_data outputs are don't-care while ready=0.

Configuration
REQ-033 Macro REGFILE_BYPASS_EN: when defined, a read whose address equals wb_addr while wb_valid=1 in RUN SHALL return wb_data and report that port not busy in the same cycle, unless a same-cycle issue_valid targets that address (REQ-026), in which case the port stays busy; when undefined, the read returns the stored value and the written value appears the cycle after the edge.

Structure
REQ-034 Package regfile_pkg SHALL hold the FSM state enum (CLEAR, RUN) and default DW/AW constants.
REQ-035 Sub-module regfile_clear_seq SHALL own the FSM and index counter, outputting ready, clr_we, and clr_idx.

Verification
REQ-036 Deassert reset_n, AW=3 -> ready=0 for 8 cycles, then 1; every register reads 0.
REQ-037 issue r5, next cycle read A=r5 -> busy_a=1, stall=1; wb r5=0x3C -> next cycle busy_a=0, rd_data_a=0x3C.
REQ-038 Same-cycle issue r2 and wb r2=0x11 -> r2=0x11, busy[2]=1 afterward.
REQ-039 Bypass build: wb r4=0xA5 while reading A=r4 -> rd_data_a=0xA5, busy_a=0 same cycle; non-bypass build -> old value, 0xA5 next cycle.
REQ-040 imm_sel=1, imm_value=0x7F, B=busy r3 -> rd_data_b=0x7F, busy_b=0, stall=0.
REQ-041 clear_req in RUN with r1=0x55, r1 busy -> busy cleared, ready low for 2**AW cycles, r1 then reads 0; R0_ZERO=1, wb r0=0xFF -> r0 reads 0.
